// File: rtl/elevator_trip_reader.sv
// Single-car elevator controller that consumes one pickup/destination request
// from a request register and runs the trip: move, open door, move, open door.
module elevator_trip_reader #(
    parameter int TOP_FLOOR   = 9,
    parameter int STEP_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] inA,
    input  logic [3:0] inB,
    input  logic       req_valid,
    output logic       req_ack,
    output logic [3:0] floor,
    output logic       up,
    output logic       down,
    output logic       door_open,
    output logic       busy,
    output logic       err,
    output logic [2:0] stateDbg
);

    // Handshake: a request is taken when req_valid is high at a rising edge in
    // IDLE; req_ack pulses for the single FETCH cycle that follows, after which
    // the writer may reload inA/inB. req_valid is ignored in every other state.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        MOVE_PICK = 3'd2,
        DOOR_PICK = 3'd3,
        MOVE_DEST = 3'd4,
        DOOR_DEST = 3'd5
    } stateT;

    localparam logic [3:0] TOP       = 4'(TOP_FLOOR);
    localparam logic [3:0] STEP_LAST = 4'(STEP_CYCLES);
    localparam logic [3:0] DOOR_LAST = 4'(DOOR_CYCLES - 1);

    stateT      state;
    stateT      nextState;
    logic [3:0] pick;
    logic [3:0] dest;
    logic [3:0] cnt;
    logic [3:0] nextCnt;
    logic [3:0] nextFloor;
    logic [3:0] target;
    logic       badReq;
    logic       errQ;

    assign stateDbg = state;
    assign err      = errQ;
    assign badReq   = (pick > TOP) || (dest > TOP);
    assign target   = (state == MOVE_DEST) ? dest : pick;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            floor <= 4'd0;
            pick  <= 4'd0;
            dest  <= 4'd0;
            cnt   <= 4'd0;
            errQ  <= 1'b0;
        end else begin
            state <= nextState;
            floor <= nextFloor;
            cnt   <= nextCnt;
            errQ  <= (state == FETCH) && badReq;
            // Latch on acceptance so a reload during FETCH cannot alter the trip.
            if (state == IDLE && req_valid) begin
                pick <= inA;
                dest <= inB;
            end
        end
    end

    always_comb begin
        nextState = state;
        nextFloor = floor;
        nextCnt   = cnt;
        req_ack   = 1'b0;
        up        = 1'b0;
        down      = 1'b0;
        door_open = 1'b0;
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                nextCnt = 4'd0;
                if (req_valid) nextState = FETCH;
            end

            FETCH: begin
                req_ack = 1'b1;
                nextCnt = 4'd0;
                if (badReq)             nextState = IDLE;
                else if (pick != floor) nextState = MOVE_PICK;
                else                    nextState = DOOR_PICK;
            end

            MOVE_PICK, MOVE_DEST: begin
                up   = (target > floor);
                down = (target < floor);
                if (cnt == STEP_LAST) begin
                    // Arrival edge hands straight over to the door state.
                    nextCnt = 4'd0;
                    if (up)        nextFloor = floor + 4'd1;
                    else if (down) nextFloor = floor - 4'd1;
                    if (nextFloor == target)
                        nextState = (state == MOVE_PICK) ? DOOR_PICK : DOOR_DEST;
                end else begin
                    nextCnt = cnt + 4'd1;
                end
            end

            DOOR_PICK, DOOR_DEST: begin
                door_open = 1'b1;
                if (cnt == DOOR_LAST) begin
                    nextCnt = 4'd0;
                    if (state == DOOR_PICK && dest != floor) nextState = MOVE_DEST;
                    else                                     nextState = IDLE;
                end else begin
                    nextCnt = cnt + 4'd1;
                end
            end

            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_elevator_trip_reader.sv
// Bench for elevator_trip_reader: directed and random trips compared cycle by
// cycle against an expected-output queue derived from floor arithmetic.
module tb_elevator_trip_reader;

    localparam int TOP  = 9;
    localparam int STEP = 4;
    localparam int DOOR = 3;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [3:0] inA = 4'd0;
    logic [3:0] inB = 4'd0;
    logic       reqValid = 1'b0;
    logic       reqAck;
    logic [3:0] floor;
    logic       up;
    logic       down;
    logic       doorOpen;
    logic       busy;
    logic       err;
    logic [2:0] stateDbg;
    logic [9:0] act;

    int errCount   = 0;
    int checkCount = 0;
    int curFloor   = 0;
    logic [9:0] exp_q[$];

    elevator_trip_reader #(
        .TOP_FLOOR(TOP), .STEP_CYCLES(STEP), .DOOR_CYCLES(DOOR)
    ) dut (
        .CLK(clk), .RST(rstN), .inA(inA), .inB(inB), .req_valid(reqValid),
        .req_ack(reqAck), .floor(floor), .up(up), .down(down),
        .door_open(doorOpen), .busy(busy), .err(err), .stateDbg(stateDbg)
    );

    always #5 clk = ~clk;

    // Packed view: {ack, up, down, door, busy, err, floor[3:0]}
    assign act = {reqAck, up, down, doorOpen, busy, err, floor};

    task automatic checkVal(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checkCount++;
        if (obs !== expv) begin
            errCount++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [9:0] vec(input logic ack, input logic u, input logic d,
                                       input logic door, input logic bsy, input logic e,
                                       input int fl);
        return {ack, u, d, door, bsy, e, 4'(fl)};
    endfunction

    task automatic pushMove(input int tgt);
        while (curFloor != tgt) begin
            repeat (STEP + 1)
                exp_q.push_back(vec(1'b0, tgt > curFloor, tgt < curFloor, 1'b0, 1'b1, 1'b0, curFloor));
            curFloor += (tgt > curFloor) ? 1 : -1;
        end
    endtask

    task automatic buildTrip(input int p, input int d);
        exp_q.delete();
        exp_q.push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, curFloor));
        if (p > TOP || d > TOP) begin
            exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, curFloor));
            return;
        end
        pushMove(p);
        repeat (DOOR) exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, curFloor));
        if (d != p) begin
            pushMove(d);
            repeat (DOOR) exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, curFloor));
        end
        exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, curFloor));
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge of
    // the idle cycle that ends the trip. Inputs are scrambled while busy.
    task automatic runTrip(input int p, input int d, input int abortFloor, input string tag);
        logic [9:0] e;
        buildTrip(p, d);
        inA = 4'(p);
        inB = 4'(d);
        reqValid = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            checkVal(tag, act, e);
            if (exp_q.size() > 0) begin
                if (abortFloor >= 0 && int'(e[3:0]) == abortFloor && e[8]) begin
                    rstN = 1'b0;
                    #1;
                    checkVal("reset_async", act, 10'h000);
                    curFloor = 0;
                    exp_q.delete();
                end else begin
                    reqValid = 1'($urandom_range(0, 1));
                    inA = 4'($urandom);
                    inB = 4'($urandom);
                end
            end else begin
                reqValid = 1'b0;
            end
        end
    endtask

    initial begin
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("reset_outputs", act, 10'h000);
        rstN = 1'b1;
        #1;
        checkVal("idle_after_reset", act, 10'h000);
        curFloor = 0;

        runTrip(3, 5, -1, "trip_3_5");
        runTrip(5, 1, -1, "trip_5_1");
        runTrip(1, 1, -1, "trip_1_1");
        runTrip(12, 2, -1, "trip_bad_12_2");
        runTrip(2, 10, -1, "trip_bad_dest");
        runTrip(8, 2, 4, "trip_abort");

        @(negedge clk);
        checkVal("reset_hold", act, 10'h000);
        inA = 4'd2;
        inB = 4'd6;
        reqValid = 1'b1;
        rstN = 1'b1;
        runTrip(2, 6, -1, "trip_after_reset");

        runTrip(TOP, 0, -1, "trip_top_to_0");
        runTrip(0, TOP, -1, "trip_0_to_top");

        for (int n = 0; n < 25; n++)
            runTrip(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), -1, "trip_rand");

        repeat (2) @(negedge clk);
        checkVal("final_idle", act, vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, curFloor));

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
